fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: synchronous memory read port plus the decode valid/ready handshake
// and the branch redirect request.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                  mem_en_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_data_i;
  logic [31:0]           inst_o;
  logic [ADDR_WIDTH-1:0] inst_pc_o;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;

  modport master (
    output mem_en_o, mem_wr_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o,
    input  mem_data_i, inst_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  mem_en_o, mem_wr_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o,
    output mem_data_i, inst_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited word reads, 2-entry instruction buffer, redirect flush.
// Optional FETCH_PERF_EN adds fetch_cnt_o, a count of instructions accepted by decode.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  fetch_unit_if.master bus_io
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_cnt_o
`endif
);

  localparam logic [2:0] BufDepth = 3'(BUF_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;
  logic [31:0]           buf_data_q [BUF_DEPTH];
  logic [31:0]           buf_data_d [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_d [BUF_DEPTH];

  logic       valid, hs, pop, push, issue;
  logic [2:0] credit_used;
  logic [1:0] wr_idx;

  assign valid       = ~rst_i & (cnt_q != 2'd0);
  assign hs          = valid & bus_io.inst_ready_i;
  assign pop         = hs & ~bus_io.redirect_i;
  assign push        = inflight_q & ~kill_q & ~bus_io.redirect_i;
  assign credit_used = {1'b0, cnt_q} + {2'b00, inflight_q};
  // A word leaving this cycle frees a slot for a read issued now.
  assign issue       = ~rst_i & ~bus_io.redirect_i & (credit_used < BufDepth + {2'b00, hs});
  assign wr_idx      = cnt_q - {1'b0, pop};

  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    kill_d     = 1'b0;
    inflight_d = issue;
    resp_pc_d  = issue ? pc_q : resp_pc_q;
    if (bus_io.redirect_i) begin
      pc_d   = bus_io.redirect_pc_i;
      cnt_d  = 2'd0;
      kill_d = inflight_q;
    end else begin
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      if (issue) pc_d = pc_q + 1'b1;
    end
  end

  always_comb begin
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < BUF_DEPTH; i++) begin
        buf_data_d[i] = buf_data_q[i+1];
        buf_pc_d[i]   = buf_pc_q[i+1];
      end
    end
    // Response data is only looked at in the cycle after an issued read.
    if (push) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        if (2'(i) == wr_idx) begin
          buf_data_d[i] = bus_io.mem_data_i;
          buf_pc_d[i]   = resp_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_data_q <= buf_data_d;
    buf_pc_q   <= buf_pc_d;
  end

  assign bus_io.mem_en_o     = issue;
  assign bus_io.mem_wr_o     = 1'b0;
  assign bus_io.mem_addr_o   = issue ? pc_q : '0;
  assign bus_io.inst_valid_o = valid;
  assign bus_io.inst_o       = valid ? buf_data_q[0] : '0;
  assign bus_io.inst_pc_o    = valid ? buf_pc_q[0] : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) fetch_cnt_q <= '0;
    else       fetch_cnt_q <= fetch_cnt_q + {31'd0, pop};
  end

  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
